// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by the transmitter and the bit timer.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_MARK = 2'd3
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int OVERSAMPLE    = 8;
  localparam int TIMER_W       = 19;

  // A prescale of zero behaves as one, so the shortest bit is OVERSAMPLE cycles.
  function automatic logic [TIMER_W-1:0] bit_period_m1(input logic [15:0] prescale);
    logic [15:0] eff;
    eff = (prescale == 16'd0) ? 16'd1 : prescale;
    return TIMER_W'(eff) * TIMER_W'(OVERSAMPLE) - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream byte/word handshake feeding the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  modport master (output s_axis_tdata, output s_axis_tvalid, input  s_axis_tready);
  modport slave  (input  s_axis_tdata, input  s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter; latches its period on load and pulses o_bit_done once per bit.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_prescale,
  output logic        o_bit_done
);

  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= bit_period_m1(i_prescale);
    end else if (i_en) begin
      r_count <= (r_count == '0) ? r_reload : r_count - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) r_reload <= bit_period_m1(i_prescale);
  end

  assign o_bit_done = i_en && (r_count == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data bits, parity and stop bits, all shadowed at acceptance.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_cfg_if.slave s_axis,
  output logic        txd,
  output logic        busy,
  input  logic [15:0] prescale,
  input  logic [3:0]  cfg_data_bits,
  input  logic [1:0]  cfg_parity,
  input  logic        cfg_stop2
);

  localparam logic [3:0] MIN_BITS = 4'(MIN_DATA_BITS);
  localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    if (n < MIN_BITS) return MIN_BITS;
    if (n > MAX_BITS) return MAX_BITS;
    return n;
  endfunction

  tx_state_t             r_state, w_state_nxt;
  logic                  r_rst_q;
  logic [3:0]            r_bit_cnt;
  logic                  r_stop_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  parity_t               r_parity;

  logic                  w_tready;
  logic                  w_accept;
  logic                  w_bit_done;
  logic [3:0]            w_nbits;
  logic                  w_xor;
  logic                  w_par;

  // Ready is held low for the cycle following any reset edge.
  assign w_tready             = (r_state == IDLE) && !r_rst_q;
  assign w_accept             = s_axis.s_axis_tvalid && w_tready;
  assign s_axis.s_axis_tready = w_tready;

  always_comb begin
    w_nbits = clamp_bits(cfg_data_bits);
    w_xor   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (4'(i) < w_nbits) w_xor = w_xor ^ s_axis.s_axis_tdata[i];
    end
    unique case (parity_t'(cfg_parity))
      PAR_EVEN: w_par = w_xor;
      PAR_ODD:  w_par = ~w_xor;
      PAR_MARK: w_par = 1'b1;
      default:  w_par = 1'b0;
    endcase
  end

  uart_bit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_en       (r_state != IDLE),
    .i_prescale (prescale),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rst_q    <= 1'b1;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rst_q <= 1'b0;
      if (w_accept) begin
        r_bit_cnt  <= w_nbits - 4'd1;
        r_stop_cnt <= cfg_stop2;
      end else if (w_bit_done) begin
        if (r_state == DATA && r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 4'd1;
        if (r_state == STOP) r_stop_cnt <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift   <= s_axis.s_axis_tdata;
      r_par_bit <= w_par;
      r_parity  <= parity_t'(cfg_parity);
    end else if (w_bit_done && r_state == DATA) begin
      r_shift <= r_shift >> 1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    txd         = 1'b1;
    busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = START;
      end
      START: begin
        txd = 1'b0;
        if (w_bit_done) w_state_nxt = DATA;
      end
      DATA: begin
        txd = r_shift[0];
        if (w_bit_done && r_bit_cnt == '0)
          w_state_nxt = (r_parity == PAR_NONE) ? STOP : PARITY;
      end
      PARITY: begin
        txd = r_par_bit;
        if (w_bit_done) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_done && !r_stop_cnt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Next-generation AXI4-Stream UART transmitter with runtime-configurable frame format.
- The frame format covers data bit count, parity mode and stop bit count.
- Data width is parametrised up to DATA_WIDTH, and the timer supports a fractional-free 16-bit prescale.
- Drop-in replacement for the transmit half of the uart wrapper. Selected per instance where serial peripherals need 7E1, 8O2 and similar formats.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame (5..9 legal).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- s_axis_tdata  input  DATA_WIDTH  byte/word to send; only the low data_bits bits are used
- s_axis_tvalid  input  1  AXI-Stream valid
- s_axis_tready  output  1  AXI-Stream ready; high only in IDLE
- txd  output  1  serial output, idle high
- busy  output  1  frame in progress
- prescale  input  16  bit period = prescale*8 clk cycles
- cfg_data_bits  input  4  data bits per frame
- cfg_parity  input  2  0 none, 1 even, 2 odd, 3 mark (always 1)
- cfg_stop2  input  1  0 one stop bit, 1 two stop bits

Behaviour:
- Reset (rst high at a clk edge): s_axis_tready=0, txd=1, busy=0, state IDLE, bit timer=0.
  - Reset mid-frame aborts immediately; txd returns to 1 on the reset edge.
- States and transitions:
  - IDLE: s_axis_tready=1 from the first cycle after reset release. On tvalid&&tready, go to START.
  - START -> DATA -> PARITY (skipped when cfg_parity=0) -> STOP -> IDLE.
- Acceptance edge (tvalid&&tready):
  - Latch tdata, cfg_data_bits, cfg_parity and cfg_stop2 into shadow registers.
  - Latch the effective prescale into the shadow as well.
  - Config or prescale changes mid-frame have no effect on the current frame.
- Cycle after acceptance: s_axis_tready=0, busy=1, txd=0 (start bit).
  - Latency from handshake to start bit is 1 cycle.
- Each bit is held for exactly prescale*8 cycles.
  - prescale=0 is treated as 1, i.e. 8 cycles per bit.
- DATA: LSB first, cfg_data_bits bits.
  - Values below 5 clamp to 5; values above DATA_WIDTH clamp to DATA_WIDTH.
- PARITY: computed over the transmitted data bits only.
  - Even: XOR of the data bits. Odd: its inverse. Mark: constant 1.
- STOP: txd=1 for 1 or 2 bit periods.
- End of frame: on the last cycle of the final stop period, the next cycle has busy=0 and s_axis_tready=1.
  - Back-to-back: with tvalid held high, the next start bit begins exactly 1 cycle after tready reasserts.
  - No idle-bit insertion.
- Frame length in bits = 1 + data_bits + (parity?1:0) + (stop2?2:1).
  - Total busy cycles = that count * prescale*8.
- tvalid dropping while tready=0 is legal and ignored; tdata is not sampled outside the handshake.
- Bit timer width: 19 bits (prescale*8). The bit counter counts down and underflow is impossible by construction.

Decomposition:
- Shared package uart_pkg holds:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK);
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - constants MIN_DATA_BITS=5 and OVERSAMPLE=8.
- One natural sub-module, uart_bit_timer:
  - loads prescale*OVERSAMPLE−1 and counts down;
  - emits a single-cycle bit_done pulse;
  - is reused by the future configurable receiver.

Test Plan:
- 8N1, prescale=1, send 0x55:
  - txd sequence 0,1,0,1,0,1,0,1,0,1, each bit held 8 cycles.
  - busy high for 80 cycles; tready back 1 cycle after.
- 7E1, prescale=2, send 0x41 (bits 1000001, two ones):
  - parity bit 0; frame of 10 bits × 16 cycles = 160 cycles.
- 8O2, prescale=1, send 0xFF:
  - parity bit 1, then two stop bits high; busy 96 cycles.
- Back-to-back 0xA5, 0x3C with tvalid held high:
  - second start bit falls exactly 1 cycle after the first frame's final stop period.
  - tready pulses high for exactly 1 cycle between frames.
- Change cfg_data_bits 8→5 and prescale 1→4 mid-frame:
  - current frame completes unchanged at 8 bits/8 cycles;
  - next frame uses 5 bits/32 cycles.
- Assert rst mid data bit 3:
  - txd=1, busy=0, tready=0 on the reset edge; tready=1 one cycle after release.
  - cfg_data_bits=2 clamps to 5 data bits.
